// File: rtl/ecc_scrub_pkg.sv
// Shared types and helpers for the ECC background scrubber.
// Holds the FSM state encoding, the SECDED width rule and counter saturation.
package ecc_scrub_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RD,
    ST_CHK,
    ST_WR
  } scrub_state_t;

  localparam int TIMER_W = 16;
  localparam logic [15:0] CNT_SAT = 16'hFFFF;

  // Hamming check bits r satisfy 2^r >= data + r + 1; one extra overall parity bit.
  function automatic int secded_width(input int data_w);
    int r;
    r = 0;
    while ((1 << r) < (data_w + r + 1)) r++;
    return data_w + r + 1;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == CNT_SAT) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ecc_scrub_timer.sv
// Loadable down-counter pacing the gap between word scrubs.
// Load wins over decrement; the count parks at zero.
module ecc_scrub_timer
  import ecc_scrub_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               dec,
  output logic               zero
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - TIMER_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/ecc_scrub_ctrl.sv
// Background scrubber: walks all addresses, reads each codeword through the
// shared SECDED decoder, writes back single-bit fixes and logs double-bit errors.
module ecc_scrub_ctrl
  import ecc_scrub_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int CODE_W = secded_width(DATA_W)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              scrub_en,
  input  logic [15:0]       interval,
  input  logic              host_busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [CODE_W-1:0] mem_wdata,
  input  logic [CODE_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [CODE_W-1:0] dec_code,
  input  logic [CODE_W-1:0] dec_fixed,
  input  logic              dec_sbe,
  input  logic              dec_dbe,
  output logic [15:0]       sbe_count,
  output logic [15:0]       dbe_count,
  output logic [ADDR_W-1:0] dbe_addr,
  output logic              dbe_irq,
  output logic              pass_done
);

  scrub_state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] maddr_d, dbe_addr_d;
  logic [CODE_W-1:0] wdata_d, code_d;
  logic [15:0]       sbe_d, dbe_d;
  logic              req_d, we_d, irq_d, done_d;
  logic              timer_load, timer_dec, timer_zero;
  logic              advance;

  ecc_scrub_timer u_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (timer_load),
    .load_val (interval),
    .dec      (timer_dec),
    .zero     (timer_zero)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Every output is computed one cycle ahead here so it leaves a flop;
  // a pending transaction always finishes even if scrub_en drops meanwhile.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    advance    = 1'b0;
    req_d      = 1'b0;
    we_d       = 1'b0;
    maddr_d    = mem_addr;
    wdata_d    = mem_wdata;
    code_d     = dec_code;
    sbe_d      = sbe_count;
    dbe_d      = dbe_count;
    dbe_addr_d = dbe_addr;
    irq_d      = 1'b0;
    done_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (scrub_en) begin
          timer_load = 1'b1;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!scrub_en) begin
          state_d = ST_IDLE;
        end else if (timer_zero && !host_busy) begin
          state_d = ST_RD;
          req_d   = 1'b1;
          maddr_d = addr_q;
        end else begin
          timer_dec = 1'b1;
        end
      end
      ST_RD: begin
        req_d = 1'b1;
        if (mem_ack) begin
          req_d   = 1'b0;
          code_d  = mem_rdata;
          state_d = ST_CHK;
        end
      end
      ST_CHK: begin
        if (dec_dbe) begin
          dbe_d      = sat_inc(dbe_count);
          dbe_addr_d = addr_q;
          irq_d      = 1'b1;
          advance    = 1'b1;
        end else if (dec_sbe) begin
          sbe_d   = sat_inc(sbe_count);
          wdata_d = dec_fixed;
          req_d   = 1'b1;
          we_d    = 1'b1;
          maddr_d = addr_q;
          state_d = ST_WR;
        end else begin
          advance = 1'b1;
        end
      end
      ST_WR: begin
        req_d = 1'b1;
        we_d  = 1'b1;
        if (mem_ack) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          advance = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (advance) begin
      addr_d = addr_q + ADDR_W'(1);
      done_d = &addr_q;
      if (scrub_en) begin
        state_d    = ST_WAIT;
        timer_load = 1'b1;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      dec_code  <= '0;
      sbe_count <= '0;
      dbe_count <= '0;
      dbe_addr  <= '0;
      dbe_irq   <= 1'b0;
      pass_done <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      mem_req   <= req_d;
      mem_we    <= we_d;
      mem_addr  <= maddr_d;
      mem_wdata <= wdata_d;
      dec_code  <= code_d;
      sbe_count <= sbe_d;
      dbe_count <= dbe_d;
      dbe_addr  <= dbe_addr_d;
      dbe_irq   <= irq_d;
      pass_done <= done_d;
    end
  end

endmodule
